// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: sequential multi-digit BCD-to-binary converter.
// Converts a packed BCD word MSD-first by Horner accumulation (acc = acc*10 + digit),
// one digit per clock, and pulses done with the result.
// Optional macro BCD2BIN_ERR_EN: builds nibble validation. An invalid operand
// reports err=1 with Binary=0. Without the macro, err is tied low and invalid
// nibbles are accumulated at face value.
module bcd_to_binary_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14,
  parameter int CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   Number,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      Binary
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state, state_nx;
  logic [4*DIGITS-1:0] sreg;
  logic [BIN_W-1:0]    acc;
  logic [BIN_W-1:0]    acc_nx;
  logic [CNT_W-1:0]    cnt;
  logic                last;
  logic                accept;

  // One Horner step on the current top nibble; *10 built as (acc<<3)+(acc<<1)
  always_comb begin
    acc_nx = (acc << 3) + (acc << 1) + BIN_W'(sreg[4*DIGITS-1 -: 4]);
    last   = (cnt == CNT_W'(DIGITS - 1));
    accept = (state == IDLE) && start;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CONV;
      CONV:    if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore output
  always_comb begin
    busy = (state == CONV);
  end

`ifdef BCD2BIN_ERR_EN
  logic bad;

  function automatic logic any_bad(input logic [4*DIGITS-1:0] w);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (w[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  // Validation flag captured with the operand, published on done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad <= 1'b0;
      err <= 1'b0;
    end else begin
      if (accept) bad <= any_bad(Number);
      if (state == CONV && last) err <= bad;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Datapath: operand capture, accumulation, result and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg   <= '0;
      acc    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      Binary <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sreg <= Number;
        acc  <= '0;
        cnt  <= '0;
      end else if (state == CONV) begin
        acc  <= acc_nx;
        sreg <= sreg << 4;
        cnt  <= cnt + CNT_W'(1);
        if (last) begin
          done <= 1'b1;
`ifdef BCD2BIN_ERR_EN
          Binary <= bad ? '0 : acc_nx;
`else
          Binary <= acc_nx;
`endif
        end
      end
    end
  end

endmodule
